fpaddsub_arbiter: RTL and testbench
===================================

# fpaddsub_arbiter

Shares one combinational `fpaddsub` datapath between `NUM_REQ` requesters. Each cycle, a round-robin arbiter selects at most one valid request and issues it to the datapath. The result then passes through a `LATENCY`-deep register pipeline and returns on a single tagged response channel with backpressure. The block sits between the issue stages of the FP lanes and the shared adder, replacing per-lane adders.

## Interface
Parameters:
- `LOG_BIT`, 5: log2 of the operand width.
- `EXP_BIT`, 8: exponent width.
- `N_BIT`, `1 << LOG_BIT`: operand width (derived).
- `NUM_REQ`, 4: number of requesters, ≥2.
- `LATENCY`, 2: number of result register stages, ≥1.
- `ID_BIT`, `$clog2(NUM_REQ)`: width of the requester tag (derived).

Ports:
- `clk` in 1: the single clock. Everything is rising-edge.
- `rst` in 1: reset. Asynchronous and active-high.
- `req_valid` in `[NUM_REQ]`: request present, one bit per requester.
- `req_ready` out `[NUM_REQ]`: request accepted this cycle.
- `req_a` in `[NUM_REQ][N_BIT]`: operand a.
- `req_b` in `[NUM_REQ][N_BIT]`: operand b.
- `req_sub` in `[NUM_REQ]`: 0 = a+b, 1 = a−b. Forwarded unchanged to `fpaddsub.addnot_sub`.
- `resp_valid` out 1: result present.
- `resp_ready` in 1: consumer takes the result.
- `resp_id` out `ID_BIT`: index of the originating requester.
- `resp_out` out `N_BIT`: IEEE result from `fpaddsub`.
- `busy` out 1: OR of all pipeline stage valids.

## Operation
- `advance = !resp_valid || resp_ready`. This is a global enable: the whole pipeline either shifts or holds.
- Arbitration:
  - Priority starts at `rr_ptr` and wraps modulo `NUM_REQ`.
  - `grant` is one-hot, or zero when no `req_valid` is set.
  - `req_ready[i] = grant[i] && advance`.
  - `req_ready` may depend combinationally on `req_valid`. Requesters must not make `req_valid` depend on `req_ready`.
  - A requester holds `req_valid`, `a`, `b` and `sub` stable until it is accepted.
- Pointer update: on an accepted request from requester g, `rr_ptr <= (g+1) mod NUM_REQ`. With no acceptance, `rr_ptr` holds.
- Datapath:
  - The muxed operands of the granted requester drive one `fpaddsub` instance.
  - `fpaddsub` output plus the grant index enter stage 1 when `advance` is high.
  - Stage k+1 takes stage k when `advance` is high. All stages hold when `advance` is low.
- Bubbles are not compressed under stall. The pipeline freezes as a whole.
- `resp_valid`, `resp_id` and `resp_out` are driven directly from the last stage's registers.
- While `resp_valid && !resp_ready`, `resp_id` and `resp_out` stay stable.
- Ordering: responses leave in acceptance order. Each requester's results are returned in its own issue order.
- Fairness: a continuously-valid requester is granted within `NUM_REQ` accepted transfers.
- Arithmetic is entirely `fpaddsub`'s: NaN in → `P_NAN`; ∞−∞ → `P_NAN`; exact zero → +0. This block never alters result bits.

## Timing
- Reset (asynchronous assert, synchronous deassert by the system):
  - All stage valids 0, stage data 0.
  - `rr_ptr` = 0.
  - `resp_valid`, `resp_id`, `resp_out`, `busy` = 0.
  - `req_ready` = 0 while `rst` is high.
- Reset mid-operation: in-flight results are discarded. No `resp_valid` for them after reset releases.
- Latency: a request accepted at edge T gives `resp_valid` high in the cycle after edge T+LATENCY−1, i.e. `LATENCY` cycles after acceptance when there is no stall.
- Throughput: one request per cycle with `resp_ready` held high.
- Stall: each cycle of `resp_valid && !resp_ready` adds exactly one cycle to every in-flight request. No grant is issued during the stall.
- Simultaneous events: a response and a new grant occur on the same edge when `resp_ready` is high. A full pipeline with `resp_ready` high still accepts.

## Structure
- Package `fpu_pkg` holds:
  - `P_NAN` and `INF` constants, parameterised by `EXP_BIT`/`N_BIT`.
  - A `fp_req_t` struct {a, b, sub}.
  - A `fp_resp_t` struct {id, out}.
- Sub-module `rr_arbiter #(NUM_REQ)`:
  - Inputs: `clk`, `rst`, `req`, `en`.
  - Outputs: one-hot `grant`, binary `grant_idx`.
  - Holds `rr_ptr` internally.
  - `en = advance` gates the pointer update.
- The top level holds one `fpaddsub` instance, the operand mux, and a `LATENCY`-entry array of {valid, `fp_resp_t`}.

## Test plan
- Single op: req0 issues a=0x3F800000, b=0x40000000, sub=0 → after 2 cycles `resp_valid`=1, `resp_id`=0, `resp_out`=0x40400000 (3.0).
- Subtract and special value: req2 issues a=0x40A00000, b=0x40400000, sub=1 → 0x40000000. Then a=b=0x7F800000, sub=1 → 0x7FC00000.
- Round robin: all four requesters valid continuously, `resp_ready`=1 → grant order 0,1,2,3,0,…. After reset with only req1 and req3 valid → 1,3,1,3.
- Backpressure: three ops back-to-back, `resp_ready`=0 for 3 cycles while the first response is presented → `resp_out` stable, `req_ready` all 0, no data loss. Responses then drain in order on consecutive cycles.
- Mid-operation reset: two ops in flight, pulse `rst` asynchronously between edges → `resp_valid`=0 and `busy`=0 immediately. No response appears after release. The first grant after release goes to the lowest valid index.
- Zero result: a=0x40400000, b=0x40400000, sub=1 → `resp_out`=0x00000000, with `resp_id` correct.

Source files
------------

// File: rtl/fpu_pkg.sv
// Shared FP constants and request/response bundles
// used by the arbitrated add/sub datapath.
package fpu_pkg;

  localparam int FP_EXP_BIT = 8;
  localparam int FP_N_BIT   = 32;
  localparam int FP_ID_BIT  = 2;

  function automatic logic [63:0] inf_bits(
    int exp_bit,
    int n_bit
  );
    logic [63:0] r;
    r = '0;
    for (int i = n_bit - 1 - exp_bit; i < n_bit - 1; i++)
      r[i] = 1'b1;
    return r;
  endfunction

  function automatic logic [63:0] nan_bits(
    int exp_bit,
    int n_bit
  );
    logic [63:0] r;
    r = inf_bits(exp_bit, n_bit);
    r[n_bit-2-exp_bit] = 1'b1;
    return r;
  endfunction

  localparam logic [FP_N_BIT-1:0] P_NAN =
    FP_N_BIT'(nan_bits(FP_EXP_BIT, FP_N_BIT));
  localparam logic [FP_N_BIT-1:0] INF =
    FP_N_BIT'(inf_bits(FP_EXP_BIT, FP_N_BIT));

  typedef struct packed {
    logic [FP_N_BIT-1:0] a;
    logic [FP_N_BIT-1:0] b;
    logic                sub;
  } fp_req_t;

  typedef struct packed {
    logic [FP_ID_BIT-1:0] id;
    logic [FP_N_BIT-1:0]  out;
  } fp_resp_t;

endpackage

// File: rtl/fpaddsub.sv
// Combinational IEEE add/sub, round-to-nearest-even,
// subnormals supported, NaN canonicalised.
module fpaddsub
  import fpu_pkg::*;
#(
  parameter int LOG_BIT = 5,
  parameter int EXP_BIT = 8,
  parameter int N_BIT   = 1 << LOG_BIT
) (
  input  logic [N_BIT-1:0] a,
  input  logic [N_BIT-1:0] b,
  input  logic             addnot_sub,
  output logic [N_BIT-1:0] out
);

  localparam int M_BIT = N_BIT - EXP_BIT - 1;
  localparam int W     = M_BIT + 5;
  localparam int E_MAX = (1 << EXP_BIT) - 1;
  localparam logic [N_BIT-1:0] NAN_W =
    N_BIT'(nan_bits(EXP_BIT, N_BIT));
  localparam logic [N_BIT-1:0] INF_W =
    N_BIT'(inf_bits(EXP_BIT, N_BIT));

  logic               sa, sb;
  logic [EXP_BIT-1:0] ea, eb;
  logic [M_BIT-1:0]   fa, fb;
  logic               a_nan, b_nan;
  logic               a_inf, b_inf;

  assign sa = a[N_BIT-1];
  assign sb = b[N_BIT-1] ^ addnot_sub;
  assign ea = a[N_BIT-2:M_BIT];
  assign eb = b[N_BIT-2:M_BIT];
  assign fa = a[M_BIT-1:0];
  assign fb = b[M_BIT-1:0];

  assign a_nan = (&ea) && (|fa);
  assign b_nan = (&eb) && (|fb);
  assign a_inf = (&ea) && !(|fa);
  assign b_inf = (&eb) && !(|fb);

  logic               swap, sx, sy, stk, up;
  logic [EXP_BIT-1:0] ex_r, ey_r;
  logic [M_BIT-1:0]   fx, fy;
  logic [W-1:0]       xs, y0, ys, sum;
  logic [W-2:0]       norm;
  logic [M_BIT+1:0]   mant;
  int                 ex, ey, sh, lz, shl, en_i;

  always_comb begin
    swap = {eb, fb} > {ea, fa};
    sx   = swap ? sb : sa;
    sy   = swap ? sa : sb;
    ex_r = swap ? eb : ea;
    ey_r = swap ? ea : eb;
    fx   = swap ? fb : fa;
    fy   = swap ? fa : fb;
    ex   = (ex_r == '0) ? 1 : int'(ex_r);
    ey   = (ey_r == '0) ? 1 : int'(ey_r);
    xs   = {1'b0, ex_r != '0, fx, 3'b000};
    y0   = {1'b0, ey_r != '0, fy, 3'b000};
    sh   = (ex - ey > W) ? W : ex - ey;
    ys   = y0 >> sh;
    // bit 0 becomes pure sticky below the round bit
    stk  = (|(y0 & ~({W{1'b1}} << sh))) | ys[0];
    ys[0] = stk;
    sum  = (sx == sy) ? xs + ys : xs - ys;

    lz = W - 1;
    for (int i = 0; i < W - 1; i++)
      if (sum[i]) lz = W - 2 - i;

    shl  = 0;
    norm = '0;
    en_i = ex;
    if (sum[W-1]) begin
      norm = sum[W-1:1] | (W-1)'(sum[0]);
      en_i = ex + 1;
    end else begin
      shl  = (lz > ex - 1) ? ex - 1 : lz;
      norm = sum[W-2:0] << shl;
      en_i = ex - shl;
    end

    up   = norm[2] && ((|norm[1:0]) || norm[3]);
    mant = {1'b0, norm[W-2:3]} + (M_BIT+2)'(up);
    if (mant[M_BIT+1]) begin
      mant = mant >> 1;
      en_i = en_i + 1;
    end
    if (!mant[M_BIT]) en_i = 0;

    out = {sx, en_i[EXP_BIT-1:0], mant[M_BIT-1:0]};
    if (en_i >= E_MAX)
      out = {sx, INF_W[N_BIT-2:0]};
    if (sum == '0)
      out = '0;
    if (a_inf)
      out = {sa, INF_W[N_BIT-2:0]};
    else if (b_inf)
      out = {sb, INF_W[N_BIT-2:0]};
    if (a_inf && b_inf && (sa != sb))
      out = NAN_W;
    if (a_nan || b_nan)
      out = NAN_W;
  end

endmodule

// File: rtl/rr_arbiter.sv
// Round-robin arbiter; the pointer moves past the
// winner only when the grant is actually taken.
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ID_BIT  = $clog2(NUM_REQ)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_REQ-1:0] req,
  input  logic               en,
  output logic [NUM_REQ-1:0] grant,
  output logic [ID_BIT-1:0]  grant_idx
);

  logic [ID_BIT-1:0] rr_ptr;
  logic              found;
  int                j;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    j         = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      j = int'(rr_ptr) + k;
      if (j >= NUM_REQ) j = j - NUM_REQ;
      if (!found && req[j]) begin
        found     = 1'b1;
        grant[j]  = 1'b1;
        grant_idx = ID_BIT'(j);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      rr_ptr <= '0;
    else if (en && found)
      rr_ptr <= (grant_idx == ID_BIT'(NUM_REQ - 1))
              ? '0 : grant_idx + 1'b1;
  end

endmodule

// File: rtl/fpaddsub_arbiter.sv
// One shared fpaddsub behind a round-robin arbiter and a
// LATENCY-deep pipeline that freezes as a whole on stall.
module fpaddsub_arbiter
  import fpu_pkg::*;
#(
  parameter int LOG_BIT = 5,
  parameter int EXP_BIT = 8,
  parameter int N_BIT   = 1 << LOG_BIT,
  parameter int NUM_REQ = 4,
  parameter int LATENCY = 2,
  parameter int ID_BIT  = $clog2(NUM_REQ)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req_valid,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic [NUM_REQ-1:0][N_BIT-1:0] req_a,
  input  logic [NUM_REQ-1:0][N_BIT-1:0] req_b,
  input  logic [NUM_REQ-1:0]            req_sub,
  output logic                          resp_valid,
  input  logic                          resp_ready,
  output logic [ID_BIT-1:0]             resp_id,
  output logic [N_BIT-1:0]              resp_out,
  output logic                          busy
);

  // bundle widths come from fpu_pkg; N_BIT and ID_BIT
  // must match FP_N_BIT and FP_ID_BIT
  logic [NUM_REQ-1:0] grant;
  logic [ID_BIT-1:0]  grant_idx;
  logic               advance;
  fp_req_t            sel;
  logic [N_BIT-1:0]   fp_out;

  logic [LATENCY-1:0] st_valid;
  fp_resp_t           st_data [LATENCY];

  assign advance = !st_valid[LATENCY-1] || resp_ready;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .ID_BIT  (ID_BIT)
  ) u_arb (
    .clk       (clk),
    .rst       (rst),
    .req       (req_valid),
    .en        (advance),
    .grant     (grant),
    .grant_idx (grant_idx)
  );

  assign req_ready = grant & {NUM_REQ{advance && !rst}};

  always_comb begin
    sel = '0;
    for (int i = 0; i < NUM_REQ; i++)
      if (grant[i]) begin
        sel.a   = req_a[i];
        sel.b   = req_b[i];
        sel.sub = req_sub[i];
      end
  end

  fpaddsub #(
    .LOG_BIT (LOG_BIT),
    .EXP_BIT (EXP_BIT),
    .N_BIT   (N_BIT)
  ) u_fp (
    .a          (sel.a),
    .b          (sel.b),
    .addnot_sub (sel.sub),
    .out        (fp_out)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st_valid <= '0;
      for (int k = 0; k < LATENCY; k++)
        st_data[k] <= '0;
    end else if (advance) begin
      st_valid[0]    <= |grant;
      st_data[0].id  <= grant_idx;
      st_data[0].out <= fp_out;
      for (int k = 1; k < LATENCY; k++) begin
        st_valid[k] <= st_valid[k-1];
        st_data[k]  <= st_data[k-1];
      end
    end
  end

  assign resp_valid = st_valid[LATENCY-1];
  assign resp_id    = st_data[LATENCY-1].id;
  assign resp_out   = st_data[LATENCY-1].out;
  assign busy       = |st_valid;

endmodule

// File: tb/tb_fpaddsub_arbiter.sv
// Bench for fpaddsub_arbiter: per-requester op queues,
// age-based in-flight model and a real-arithmetic FP model.
module tb_fpaddsub_arbiter;
  import fpu_pkg::*;

  localparam int NR  = 4;
  localparam int LAT = 2;
  localparam int NB  = 32;
  localparam int IDB = 2;

  logic                   clk = 1'b0;
  logic                   rst = 1'b0;
  logic [NR-1:0]          req_valid;
  logic [NR-1:0]          req_ready;
  logic [NR-1:0][NB-1:0]  req_a;
  logic [NR-1:0][NB-1:0]  req_b;
  logic [NR-1:0]          req_sub;
  logic                   resp_valid;
  logic                   resp_ready;
  logic [IDB-1:0]         resp_id;
  logic [NB-1:0]          resp_out;
  logic                   busy;

  always #5 clk = ~clk;

  fpaddsub_arbiter #(
    .LOG_BIT (5),
    .EXP_BIT (8),
    .NUM_REQ (NR),
    .LATENCY (LAT)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_a      (req_a),
    .req_b      (req_b),
    .req_sub    (req_sub),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_id    (resp_id),
    .resp_out   (resp_out),
    .busy       (busy)
  );

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        sub;
    logic [31:0] exp;
  } op_t;

  typedef struct {
    int          id;
    logic [31:0] exp;
    int          age;
  } fl_t;

  op_t pend [NR][$];
  fl_t fl [$];
  int  ptr;
  int  n_vec;
  int  n_mis;

  task automatic check(
    input string       tag,
    input logic [63:0] got,
    input logic [63:0] exp
  );
    n_vec++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got %h expected %h @%0t",
               tag, got, exp, $time);
    end
  endtask

  function automatic real sp_to_real(
    input logic [31:0] x,
    input logic        s
  );
    int  e;
    real m;
    e = int'(x[30:23]);
    m = real'(x[22:0]);
    if (e != 0) m = m + 8388608.0;
    else e = 1;
    m = m * (2.0 ** (e - 150));
    return s ? -m : m;
  endfunction

  // double has > 2p+2 bits, so rounding twice is exact
  function automatic logic [31:0] real_to_sp(input real r);
    logic [63:0] d, mm, q, rem, half;
    int          es, sh;
    d  = $realtobits(r);
    es = int'(d[62:52]) - 1023 + 127;
    mm = {11'b0, 1'b1, d[51:0]};
    sh = (es >= 1) ? 29 : 29 + 1 - es;
    if (sh > 60) return {d[63], 31'b0};
    q    = mm >> sh;
    rem  = mm & ((64'd1 << sh) - 64'd1);
    half = 64'd1 << (sh - 1);
    if (rem > half || (rem == half && q[0])) q = q + 1;
    if (es >= 1) begin
      if (q[24]) begin
        q  = q >> 1;
        es = es + 1;
      end
      if (es >= 255) return {d[63], INF[30:0]};
      return {d[63], 8'(es), q[22:0]};
    end
    return {d[63], q[30:0]};
  endfunction

  function automatic logic [31:0] fp_ref(
    input logic [31:0] a,
    input logic [31:0] b,
    input logic        sub
  );
    logic sa, sb, an, bn, ai, bi;
    real  r;
    sa = a[31];
    sb = b[31] ^ sub;
    an = (a[30:23] == 8'hff) && (a[22:0] != 0);
    bn = (b[30:23] == 8'hff) && (b[22:0] != 0);
    ai = (a[30:23] == 8'hff) && (a[22:0] == 0);
    bi = (b[30:23] == 8'hff) && (b[22:0] == 0);
    if (an || bn) return P_NAN;
    if (ai && bi)
      return (sa == sb) ? {sa, INF[30:0]} : P_NAN;
    if (ai) return {sa, INF[30:0]};
    if (bi) return {sb, INF[30:0]};
    r = sp_to_real(a, sa) + sp_to_real(b, sb);
    if (r == 0.0) return 32'h0;
    return real_to_sp(r);
  endfunction

  function automatic logic [31:0] rnd_fp();
    logic [31:0] f;
    int          m;
    f = $urandom;
    m = $urandom_range(0, 15);
    case (m)
      0: return {f[31], 31'b0};
      1: return {f[31], 8'hff, 23'b0};
      2: return {f[31], 8'hff, f[22:0] | 23'h1};
      3: return {f[31], 8'h00, f[22:0]};
      4: return {f[31], 8'(254 - int'(f[1:0])), f[22:0]};
      5: return {f[31], 8'(1 + int'(f[1:0])), f[22:0]};
      default:
        return {f[31], 8'($urandom_range(118, 137)),
                f[22:0]};
    endcase
  endfunction

  task automatic push(
    input int          r,
    input logic [31:0] a,
    input logic [31:0] b,
    input logic        sub,
    input logic [31:0] e
  );
    op_t o;
    o.a   = a;
    o.b   = b;
    o.sub = sub;
    o.exp = e;
    pend[r].push_back(o);
  endtask

  task automatic push_rnd(input int r);
    logic [31:0] a, b;
    logic        s;
    a = rnd_fp();
    if ($urandom_range(0, 5) == 0)
      b = a ^ ($urandom & 32'h7);
    else
      b = rnd_fp();
    s = 1'($urandom);
    push(r, a, b, s, fp_ref(a, b, s));
  endtask

  function automatic bit any_pend();
    for (int r = 0; r < NR; r++)
      if (pend[r].size() > 0) return 1'b1;
    return 1'b0;
  endfunction

  task automatic drive();
    for (int r = 0; r < NR; r++) begin
      if (pend[r].size() > 0) begin
        req_valid[r] = 1'b1;
        req_a[r]     = pend[r][0].a;
        req_b[r]     = pend[r][0].b;
        req_sub[r]   = pend[r][0].sub;
      end else begin
        req_valid[r] = 1'b0;
        req_a[r]     = '0;
        req_b[r]     = '0;
        req_sub[r]   = 1'b0;
      end
    end
  endtask

  task automatic cycle(input logic rdy);
    logic          mv, adv;
    int            g, j;
    logic [NR-1:0] er;
    fl_t           n;
    resp_ready = rdy;
    drive();
    @(negedge clk);
    mv  = (fl.size() > 0) && (fl[0].age == LAT);
    adv = !mv || rdy;
    g   = -1;
    for (int k = 0; k < NR; k++) begin
      j = (ptr + k) % NR;
      if (g < 0 && pend[j].size() > 0) g = j;
    end
    er = '0;
    if (g >= 0 && adv) er[g] = 1'b1;
    check("req_ready", 64'(req_ready), 64'(er));
    check("resp_valid", 64'(resp_valid), 64'(mv));
    if (mv) begin
      check("resp_id", 64'(resp_id), 64'(fl[0].id));
      check("resp_out", 64'(resp_out), 64'(fl[0].exp));
    end
    check("busy", 64'(busy), 64'(fl.size() > 0));
    if (adv) begin
      if (mv) void'(fl.pop_front());
      foreach (fl[i]) fl[i].age++;
      if (g >= 0) begin
        n.id  = g;
        n.exp = pend[g][0].exp;
        n.age = 1;
        fl.push_back(n);
        void'(pend[g].pop_front());
        ptr = (g + 1) % NR;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic mid_reset();
    #2;
    rst = 1'b1;
    #1;
    check("rst_resp_valid", 64'(resp_valid), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_req_ready", 64'(req_ready), 64'd0);
    check("rst_resp_out", 64'(resp_out), 64'd0);
    fl.delete();
    ptr = 0;
    @(posedge clk);
    #1;
    check("rst_hold_ready", 64'(req_ready), 64'd0);
    rst = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((any_pend() || fl.size() > 0) && n < 400) begin
      cycle(1'b1);
      n++;
    end
    check("drain_left", 64'(fl.size()), 64'd0);
  endtask

  initial begin
    n_vec      = 0;
    n_mis      = 0;
    ptr        = 0;
    resp_ready = 1'b1;
    push(0, 32'h3F800000, 32'h40000000, 1'b0,
         32'h40400000);
    drive();
    #1 rst = 1'b1;
    #1;
    check("reset_valid", 64'(resp_valid), 64'd0);
    check("reset_busy", 64'(busy), 64'd0);
    check("reset_id", 64'(resp_id), 64'd0);
    check("reset_out", 64'(resp_out), 64'd0);
    check("reset_ready", 64'(req_ready), 64'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    drain();

    push(2, 32'h40A00000, 32'h40400000, 1'b1,
         32'h40000000);
    push(2, 32'h7F800000, 32'h7F800000, 1'b1,
         32'h7FC00000);
    drain();

    push(1, 32'h40400000, 32'h40400000, 1'b1,
         32'h00000000);
    drain();

    for (int r = 0; r < NR; r++)
      repeat (6) push_rnd(r);
    drain();

    mid_reset();
    repeat (4) begin
      push_rnd(1);
      push_rnd(3);
    end
    drain();

    push(0, 32'h3F800000, 32'h3F800000, 1'b0,
         32'h40000000);
    push(1, 32'h40400000, 32'h3F800000, 1'b1,
         32'h40000000);
    push(2, 32'hC0000000, 32'h40800000, 1'b0,
         32'h40000000);
    cycle(1'b1);
    cycle(1'b1);
    repeat (3) cycle(1'b0);
    drain();

    push_rnd(0);
    push_rnd(3);
    push_rnd(2);
    cycle(1'b1);
    cycle(1'b1);
    mid_reset();
    drain();

    for (int c = 0; c < 3000; c++) begin
      for (int r = 0; r < NR; r++)
        if (pend[r].size() < 3 &&
            $urandom_range(0, 2) == 0)
          push_rnd(r);
      if ($urandom_range(0, 599) == 0)
        mid_reset();
      cycle($urandom_range(0, 3) != 0);
    end
    drain();

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_mis);
    $finish;
  end

endmodule
